// File: rtl/signed_div_seq.sv
`default_nettype none
// ============================================================================
// Module   : signed_div_seq
// Brief    : Sequential signed fixed-point divider, q = (a << FRAC) / b, one
//            quotient bit per clock, with saturation and divide-by-zero flags.
// Revision : 1.0 - initial release
// ============================================================================
module signed_div_seq #(
    parameter int WIDTH = 8,
    parameter int FRAC  = 6
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_quotient,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_div_by_zero,
    output logic             o_overflow
);

    localparam int NUM_W = WIDTH + FRAC;
    localparam int CNT_W = $clog2(NUM_W);
    localparam logic [CNT_W-1:0] c_LAST_ITER = CNT_W'(NUM_W - 1);
    localparam logic [NUM_W-1:0] c_POS_LIMIT = NUM_W'(2 ** (WIDTH - 1) - 1);
    localparam logic [NUM_W-1:0] c_NEG_LIMIT = NUM_W'(2 ** (WIDTH - 1));
    localparam logic [WIDTH-1:0] c_Q_MAX     = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] c_Q_MIN     = {1'b1, {(WIDTH-1){1'b0}}};

    // S_FIN is the single cycle in which the saturated result is loaded.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               w_accept;

    logic               r_sign;
    logic               r_a_neg;
    logic               r_dbz;
    logic [WIDTH-1:0]   r_mag_b;
    logic [NUM_W-1:0]   r_num;
    logic [WIDTH-1:0]   r_rem;
    logic [NUM_W-1:0]   r_quo;
    logic [CNT_W-1:0]   r_cnt;

    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_trial;
    logic               w_ge;
    logic [WIDTH-1:0]   w_rem_sub;
    logic [WIDTH-1:0]   w_sat_q;
    logic               w_sat_ovf;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        o_ready  = 1'b0;
        o_valid  = 1'b0;
        w_accept = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    w_accept = 1'b1;
                    w_next   = (i_b == '0) ? S_FIN : S_CALC;
                end
            end
            S_CALC: begin
                if (r_cnt == c_LAST_ITER) begin
                    w_next = S_FIN;
                end
            end
            S_FIN: begin
                w_next = S_DONE;
            end
            S_DONE: begin
                o_valid = 1'b1;
                if (i_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Unsigned magnitudes: the most negative operand maps to 2^(WIDTH-1) exactly.
    assign w_mag_a   = i_a[WIDTH-1] ? (~i_a + 1'b1) : i_a;
    assign w_mag_b   = i_b[WIDTH-1] ? (~i_b + 1'b1) : i_b;
    assign w_trial   = {r_rem, r_num[NUM_W-1]};
    assign w_ge      = (w_trial >= {1'b0, r_mag_b});
    assign w_rem_sub = WIDTH'(w_trial - {1'b0, r_mag_b});

    always_comb begin
        w_sat_q   = r_quo[WIDTH-1:0];
        w_sat_ovf = 1'b0;
        if (r_dbz) begin
            w_sat_q = r_a_neg ? c_Q_MIN : c_Q_MAX;
        end else if (!r_sign) begin
            if (r_quo > c_POS_LIMIT) begin
                w_sat_q   = c_Q_MAX;
                w_sat_ovf = 1'b1;
            end
        end else if (r_quo > c_NEG_LIMIT) begin
            w_sat_q   = c_Q_MIN;
            w_sat_ovf = 1'b1;
        end else begin
            // A magnitude of exactly 2^(WIDTH-1) negates to the minimum code.
            w_sat_q = ~r_quo[WIDTH-1:0] + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sign        <= 1'b0;
            r_a_neg       <= 1'b0;
            r_dbz         <= 1'b0;
            r_mag_b       <= '0;
            r_num         <= '0;
            r_rem         <= '0;
            r_quo         <= '0;
            r_cnt         <= '0;
            o_quotient    <= '0;
            o_div_by_zero <= 1'b0;
            o_overflow    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_sign  <= i_a[WIDTH-1] ^ i_b[WIDTH-1];
                r_a_neg <= i_a[WIDTH-1];
                r_dbz   <= (i_b == '0);
                r_mag_b <= w_mag_b;
                r_num   <= {w_mag_a, {FRAC{1'b0}}};
                r_rem   <= '0;
                r_quo   <= '0;
                r_cnt   <= '0;
            end else if (r_state == S_CALC) begin
                r_num <= {r_num[NUM_W-2:0], 1'b0};
                r_rem <= w_ge ? w_rem_sub : w_trial[WIDTH-1:0];
                r_quo <= {r_quo[NUM_W-2:0], w_ge};
                r_cnt <= r_cnt + 1'b1;
            end else if (r_state == S_FIN) begin
                o_quotient    <= w_sat_q;
                o_div_by_zero <= r_dbz;
                o_overflow    <= w_sat_ovf;
            end
        end
    end

endmodule
`default_nettype wire
